zdos_trap: RTL and testbench

- Parametrised DOS-mode controller; replaces the fixed on/off DOS flag.
- Detects Z80 M1 opcode fetches into a configurable set of ROM trap pages and sets DOS.
- Clears DOS on M1 fetches from RAM, after a programmable number of such fetches, or on a software request.
- Reports which trap caused entry, and emits entry and exit pulses for the memory-mapping and port-decode logic.

---
 rtl/zdos_trap.sv | 97 +++++++++
 tb/tb_zdos_trap.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/zdos_trap.sv
// DOS-mode controller: enters DOS on M1 fetches into ROM trap pages, CP/M mode or a
// software request; leaves it on RAM M1 fetches (with optional delay) or software request.
module zdos_trap #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned OFF_DELAY = 0,
    parameter int unsigned CNTW      = 4,
    parameter int unsigned SRCW      = 2
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              m1_stb,
    input  logic [15:0]       za,
    input  logic              rom_act,
    input  logic [NCH*8-1:0]  win_hi,
    input  logic [NCH-1:0]    win_en,
    input  logic              sw_on,
    input  logic              sw_off,
    input  logic              cpm_n,
    output logic              dos,
    output logic [SRCW-1:0]   dos_src,
    output logic              dos_rise,
    output logic              dos_fall
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(OFF_DELAY);
    localparam logic [SRCW-1:0] SRC_SW   = SRCW'(NCH);
    localparam logic [SRCW-1:0] SRC_CPM  = SRCW'(NCH + 1);

    logic [CNTW-1:0] cnt;
    logic [NCH-1:0]  hit_v;
    logic            hit;
    logic [SRCW-1:0] hit_idx;
    logic            ram_f;
    logic            rom_f;
    logic            unused_lo;

    assign unused_lo = ^za[7:0];

    // Per-window trap match and lowest-index priority encode
    always_comb begin
        hit_v   = '0;
        hit_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            hit_v[i] = m1_stb & win_en[i] & rom_act & (za[15:8] == win_hi[8*i +: 8]);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit_v[i]) hit_idx = SRCW'(i);
        end
        hit   = |hit_v;
        ram_f = m1_stb & (za[15:14] != 2'b00);
        rom_f = m1_stb & (za[15:14] == 2'b00);
    end

    // DOS flag, off-delay counter, entry cause and edge pulses
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            dos      <= 1'b0;
            dos_src  <= '0;
            dos_rise <= 1'b0;
            dos_fall <= 1'b0;
            cnt      <= '0;
        end else begin
            dos_rise <= 1'b0;
            dos_fall <= 1'b0;
            if (!cpm_n) begin
                dos <= 1'b1;
                cnt <= '0;
                if (!dos) begin
                    dos_src  <= SRC_CPM;
                    dos_rise <= 1'b1;
                end
            end else if (sw_off) begin
                dos <= 1'b0;
                cnt <= '0;
                if (dos) dos_fall <= 1'b1;
            end else if (dos && ram_f) begin
                if (cnt == CNT_LAST) begin
                    dos      <= 1'b0;
                    cnt      <= '0;
                    dos_fall <= 1'b1;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end else if (sw_on || hit) begin
                dos <= 1'b1;
                cnt <= '0;
                if (!dos) begin
                    dos_src  <= sw_on ? SRC_SW : hit_idx;
                    dos_rise <= 1'b1;
                end
            end else if (dos && rom_f) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_zdos_trap.sv
// Bench for zdos_trap: two instances (OFF_DELAY 0 and 2) on shared inputs, checked
// against a rule-level model through directed steps followed by random traffic.
module tb_zdos_trap;

    localparam int unsigned NCH  = 2;
    localparam int unsigned SRCW = 2;

    logic              fclk;
    logic              rst_n;
    logic              m1_stb;
    logic [15:0]       za;
    logic              rom_act;
    logic [NCH*8-1:0]  win_hi;
    logic [NCH-1:0]    win_en;
    logic              sw_on;
    logic              sw_off;
    logic              cpm_n;

    logic              dos [2];
    logic [SRCW-1:0]   dos_src [2];
    logic              dos_rise [2];
    logic              dos_fall [2];

    int passed = 0;
    int total  = 0;

    // Model state: flag, cause, consecutive RAM fetches seen while in DOS
    int m_dos [2];
    int m_src [2];
    int m_run [2];
    int m_rise [2];
    int m_fall [2];
    int delay [2] = '{0, 2};

    zdos_trap #(.NCH(NCH), .OFF_DELAY(0), .CNTW(4), .SRCW(SRCW)) dut0 (
        .fclk(fclk), .rst_n(rst_n), .m1_stb(m1_stb), .za(za), .rom_act(rom_act),
        .win_hi(win_hi), .win_en(win_en), .sw_on(sw_on), .sw_off(sw_off), .cpm_n(cpm_n),
        .dos(dos[0]), .dos_src(dos_src[0]), .dos_rise(dos_rise[0]), .dos_fall(dos_fall[0])
    );

    zdos_trap #(.NCH(NCH), .OFF_DELAY(2), .CNTW(4), .SRCW(SRCW)) dut1 (
        .fclk(fclk), .rst_n(rst_n), .m1_stb(m1_stb), .za(za), .rom_act(rom_act),
        .win_hi(win_hi), .win_en(win_en), .sw_on(sw_on), .sw_off(sw_off), .cpm_n(cpm_n),
        .dos(dos[1]), .dos_src(dos_src[1]), .dos_rise(dos_rise[1]), .dos_fall(dos_fall[1])
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int trap_window();
        if (!m1_stb || !rom_act) return -1;
        for (int i = 0; i < NCH; i++)
            if (win_en[i] && za[15:8] == win_hi[8*i +: 8]) return i;
        return -1;
    endfunction

    task automatic model(input int d);
        int  prev;
        int  w;
        bit  is_ram;
        prev   = m_dos[d];
        w      = trap_window();
        is_ram = m1_stb && (za >= 16'h4000);
        m_rise[d] = 0;
        m_fall[d] = 0;
        if (!rst_n) begin
            m_dos[d] = 0; m_src[d] = 0; m_run[d] = 0;
            return;
        end
        if (!cpm_n) begin
            m_dos[d] = 1; m_run[d] = 0;
            if (prev == 0) m_src[d] = NCH + 1;
        end else if (sw_off) begin
            m_dos[d] = 0; m_run[d] = 0;
        end else if (prev == 1 && is_ram) begin
            m_run[d] = m_run[d] + 1;
            if (m_run[d] > delay[d]) begin
                m_dos[d] = 0; m_run[d] = 0;
            end
        end else if (sw_on || w >= 0) begin
            m_dos[d] = 1; m_run[d] = 0;
            if (prev == 0) m_src[d] = sw_on ? NCH : w;
        end else if (prev == 1 && m1_stb) begin
            m_run[d] = 0;
        end
        m_rise[d] = (prev == 0 && m_dos[d] == 1) ? 1 : 0;
        m_fall[d] = (prev == 1 && m_dos[d] == 0) ? 1 : 0;
    endtask

    // Advance one clock with the current inputs, then compare both instances
    task automatic step(input string tag);
        model(0);
        model(1);
        @(posedge fclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.dos", tag, d),  8'(dos[d]),      8'(m_dos[d]));
            chk($sformatf("%s.d%0d.src", tag, d),  8'(dos_src[d]),  8'(m_src[d]));
            chk($sformatf("%s.d%0d.rise", tag, d), 8'(dos_rise[d]), 8'(m_rise[d]));
            chk($sformatf("%s.d%0d.fall", tag, d), 8'(dos_fall[d]), 8'(m_fall[d]));
        end
        m1_stb = 1'b0;
        sw_on  = 1'b0;
        sw_off = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic fetch(input logic [15:0] a, input string tag);
        m1_stb = 1'b1;
        za     = a;
        step(tag);
    endtask

    initial begin
        fclk = 1'b0;
        rst_n = 1'b0; m1_stb = 1'b0; za = 16'h0000; rom_act = 1'b1;
        win_hi = {8'h3D, 8'h1E}; win_en = 2'b11;
        sw_on = 1'b0; sw_off = 1'b0; cpm_n = 1'b1;
        foreach (m_dos[d]) begin
            m_dos[d] = 0; m_src[d] = 0; m_run[d] = 0; m_rise[d] = 0; m_fall[d] = 0;
        end
        #2;
        step("reset");
        chk("reset_dos", 8'(dos[0]), 8'd0);

        fetch(16'h3D2F, "trap_entry");
        chk("entry_dos", 8'(dos[0]), 8'd1);
        chk("entry_src", 8'(dos_src[0]), 8'd1);
        chk("entry_rise", 8'(dos_rise[0]), 8'd1);
        step("entry_idle");
        chk("entry_rise_once", 8'(dos_rise[0]), 8'd0);

        fetch(16'h5B00, "exit_d0");
        chk("exit_dos", 8'(dos[0]), 8'd0);
        chk("exit_fall", 8'(dos_fall[0]), 8'd1);
        chk("exit_src_held", 8'(dos_src[0]), 8'd1);
        chk("exit_d1_hold", 8'(dos[1]), 8'd1);
        step("exit_idle");

        sw_off = 1'b1; step("clr");
        sw_on = 1'b1; step("swon");
        fetch(16'h8000, "delay_r1");
        fetch(16'h8000, "delay_r2");
        chk("delay_two_ram", 8'(dos[1]), 8'd1);
        fetch(16'h8000, "delay_r3");
        chk("delay_third_ram", 8'(dos[1]), 8'd0);
        chk("delay_third_fall", 8'(dos_fall[1]), 8'd1);

        sw_on = 1'b1; step("swon2");
        fetch(16'h8000, "brk_r1");
        fetch(16'h8000, "brk_r2");
        fetch(16'h0038, "brk_rom");
        fetch(16'h8000, "brk_r3");
        fetch(16'h8000, "brk_r4");
        chk("run_broken", 8'(dos[1]), 8'd1);

        sw_off = 1'b1; step("clr2");
        win_en = 2'b00; fetch(16'h3D00, "mask_en");
        win_en = 2'b11; rom_act = 1'b0; fetch(16'h3D00, "mask_rom");
        rom_act = 1'b1; za = 16'h3D00; step("mask_nom1");
        chk("mask_dos", 8'(dos[0]), 8'd0);

        cpm_n = 1'b0; sw_off = 1'b1; fetch(16'h8000, "cpm_prio");
        chk("cpm_dos", 8'(dos[1]), 8'd1);
        chk("cpm_src", 8'(dos_src[1]), 8'd3);
        sw_off = 1'b1; fetch(16'hC000, "cpm_hold");
        cpm_n = 1'b1; step("cpm_release");
        chk("cpm_release_dos", 8'(dos[0]), 8'd1);
        sw_off = 1'b1; step("clr3");
        sw_on = 1'b1; fetch(16'h1E00, "swon_hit");
        chk("swon_wins", 8'(dos_src[0]), 8'd2);
        sw_off = 1'b1; step("clr4");
        sw_off = 1'b1; fetch(16'h1E00, "swoff_hit");
        chk("swoff_wins", 8'(dos[0]), 8'd0);

        sw_on = 1'b1; step("rst_on");
        fetch(16'h8000, "rst_cnt1");
        rst_n = 1'b0; step("rst_mid");
        chk("rst_dos", 8'(dos[1]), 8'd0);
        chk("rst_nofall", 8'(dos_fall[1]), 8'd0);
        sw_on = 1'b1; step("rst_on2");
        fetch(16'h8000, "rst_ram");
        chk("rst_cnt_clear", 8'(dos[1]), 8'd1);

        // Random traffic biased toward trap pages and ROM/RAM boundaries
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 49) != 0);
            cpm_n   = ($urandom_range(0, 19) != 0);
            sw_on   = ($urandom_range(0, 9) == 0);
            sw_off  = ($urandom_range(0, 11) == 0);
            m1_stb  = ($urandom_range(0, 2) != 0);
            rom_act = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) win_en = 2'($urandom);
            if ($urandom_range(0, 49) == 0) win_hi = {8'($urandom_range(0, 63)), 8'h1E};
            case ($urandom_range(0, 3))
                0: za = {8'h3D, 8'($urandom)};
                1: za = {8'h1E, 8'($urandom)};
                2: za = {2'b00, 14'($urandom)};
                default: za = 16'($urandom);
            endcase
            step($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
